// File: rtl/mac_seq_ctrl.sv
// Weighted-sum sequencer: walks a 9:1 operand mux and accumulates Q8.8 products.
// The result is the accumulator scaled back to Q8.8 and saturated to 16 bits.
module mac_seq_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  length,
  output logic [3:0]  select,
  input  logic [15:0] mux_data,
  input  logic [15:0] weight,
  output logic        busy,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] result
);

  // state | meaning
  // IDLE  | waiting for start with a non-zero length
  // RUN   | one product accumulated per cycle, select = operand counter
  // DONE  | result presented, held until res_ready
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [35:0] acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [3:0]         len_q, len_d;

  logic signed [31:0] product;
  logic signed [27:0] shifted;
  logic               start_ok;
  logic [3:0]         len_eff;

  assign product  = $signed(mux_data) * $signed(weight);
  assign start_ok = start && (length != 4'd0);
  assign len_eff  = (length > 4'd9) ? 4'd9 : length;
  // Dropping the low 8 bits of a two's complement value rounds toward -inf
  assign shifted  = acc_q[35:8];

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          acc_d   = '0;
          cnt_d   = '0;
          len_d   = len_eff;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + {{4{product[31]}}, product};
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == len_q - 4'd1) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          if (start_ok) begin
            acc_d   = '0;
            cnt_d   = '0;
            len_d   = len_eff;
            state_d = RUN;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    select    = 4'd0;
    busy      = 1'b0;
    res_valid = 1'b0;
    result    = 16'd0;
    case (state_q)
      RUN: begin
        select = cnt_q;
        busy   = 1'b1;
      end
      DONE: begin
        res_valid = 1'b1;
        if (shifted > 28'sd32767) begin
          result = 16'h7FFF;
        end else if (shifted < -28'sd32768) begin
          result = 16'h8000;
        end else begin
          result = shifted[15:0];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Scoreboard bench for mac_seq_ctrl: expected sums are queued at launch and
// compared when the result appears.
module tb_mac_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  length;
  logic [3:0]  select;
  logic [15:0] mux_data;
  logic [15:0] weight;
  logic        busy;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] result;

  logic [15:0] op_arr [16];
  logic [15:0] w_arr  [16];
  logic [15:0] exp_q [$];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign mux_data = op_arr[select];
  assign weight   = w_arr[select];

  mac_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .length    (length),
    .select    (select),
    .mux_data  (mux_data),
    .weight    (weight),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .result    (result)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input int n);
    longint acc = 0;
    longint sh;
    for (int i = 0; i < n; i++) begin
      acc += longint'($signed(op_arr[i])) * longint'($signed(w_arr[i]));
    end
    sh = acc >>> 8;
    if (sh > 32767) return 16'h7FFF;
    if (sh < -32768) return 16'h8000;
    return sh[15:0];
  endfunction

  task automatic set_ops(input logic [15:0] o, input logic [15:0] w);
    for (int i = 0; i < 16; i++) begin
      op_arr[i] = o;
      w_arr[i]  = w;
    end
  endtask

  task automatic set_rand();
    for (int i = 0; i < 16; i++) begin
      op_arr[i] = 16'($urandom);
      w_arr[i]  = 16'($urandom);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic launch(input int len_in);
    int eff;
    eff = (len_in > 9) ? 9 : len_in;
    length = 4'(len_in);
    start  = 1'b1;
    exp_q.push_back(model(eff));
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic finish_pass(input int eff, input int bp, input bit mid_start, input bit release_res);
    int cycles = 1;
    int busy_n = 0;
    logic [15:0] hold;
    logic [15:0] e;
    while (!res_valid && cycles < 20) begin
      if (busy) begin
        check_eq("select", select, busy_n);
        busy_n++;
      end
      if (mid_start && busy_n == 2) begin
        start  = 1'b1;
        length = 4'd1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
    end
    check_eq("latency", cycles, eff + 1);
    check_eq("busy_cycles", busy_n, eff);
    hold = result;
    for (int i = 0; i < bp; i++) begin
      start  = 1'b1;
      length = 4'd5;
      @(posedge clk); #1;
      check_eq("bp_valid", res_valid, 1);
      check_eq("bp_result", result, hold);
    end
    start = 1'b0;
    if (exp_q.size() == 0) begin
      check_eq("queue_empty", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check_eq("result", result, e);
    end
    if (release_res) begin
      res_ready = 1'b1;
      @(posedge clk); #1;
      res_ready = 1'b0;
      check_eq("rel_valid", res_valid, 0);
      check_eq("rel_busy", busy, 0);
    end
  endtask

  initial begin
    int k;
    int l;
    rst       = 1'b1;
    start     = 1'b0;
    length    = 4'd0;
    res_ready = 1'b0;
    set_ops(16'h0, 16'h0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_select", select, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", res_valid, 0);
    check_eq("rst_result", result, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    set_ops(16'h0100, 16'h0100);
    launch(9);
    finish_pass(9, 0, 0, 1);

    set_ops(16'h7FFF, 16'h7FFF);
    launch(9);
    finish_pass(9, 0, 0, 1);

    set_ops(16'h8000, 16'h7FFF);
    launch(9);
    finish_pass(9, 0, 0, 1);

    length = 4'd0;
    start  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_eq("len0_busy", busy, 0);
      check_eq("len0_valid", res_valid, 0);
    end
    start = 1'b0;

    set_ops(16'h0100, 16'h0100);
    launch(12);
    finish_pass(9, 0, 0, 1);

    set_ops(16'h0200, 16'hFF00);
    launch(1);
    finish_pass(1, 0, 0, 1);

    set_rand();
    launch(5);
    finish_pass(5, 5, 0, 1);

    set_rand();
    launch(7);
    finish_pass(7, 0, 1, 1);

    set_rand();
    launch(4);
    finish_pass(4, 0, 0, 0);
    set_rand();
    length    = 4'd3;
    start     = 1'b1;
    res_ready = 1'b1;
    exp_q.push_back(model(3));
    @(posedge clk); #1;
    start     = 1'b0;
    res_ready = 1'b0;
    check_eq("b2b_busy", busy, 1);
    check_eq("b2b_select", select, 0);
    finish_pass(3, 0, 0, 1);

    set_rand();
    launch(9);
    k = 0;
    while (select != 4'd4 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check_eq("abort_reach", select, 4);
    #2 rst = 1'b1;
    #1;
    check_eq("abort_select", select, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_valid", res_valid, 0);
    check_eq("abort_result", result, 0);
    void'(exp_q.pop_front());
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check_eq("post_abort_valid", res_valid, 0);
    set_rand();
    launch(3);
    finish_pass(3, 0, 0, 1);

    for (int p = 0; p < 6; p++) begin
      set_rand();
      l = $urandom_range(1, 15);
      launch(l);
      finish_pass((l > 9) ? 9 : l, 0, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
